// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared gesture states and counter width helper
package btn_evt_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, WAIT2, PRESS2} state_t;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b);
  endfunction
endpackage

// File: rtl/evt_tick_counter.sv
// evt_tick_counter: tick counter with sync clear/enable and terminal compare
module evt_tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign done = cnt == limit;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses into short/long/double pulses
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_TICKS   = 100_000_000,
  parameter int DCLICK_TICKS = 25_000_000,
  localparam int CNT_W       = cnt_width(LONG_TICKS, DCLICK_TICKS)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);
  state_t state, next_state;
  logic btn_q, rise, fall, done, sp_n, lp_n, dp_n;
  logic [CNT_W-1:0] cnt, limit;
  assign rise  = btn & ~btn_q;
  assign fall  = ~btn & btn_q;
  assign limit = state == WAIT2 ? CNT_W'(DCLICK_TICKS - 1) : CNT_W'(LONG_TICKS - 1);
  // saturation guard only; the terminal compare always leaves the state first
  evt_tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (next_state != state),
    .en    ((state == PRESS1 || state == WAIT2) && cnt != '1),
    .limit (limit),
    .cnt   (cnt),
    .done  (done)
  );
  always_comb begin
    next_state = state;
    sp_n = 1'b0;
    lp_n = 1'b0;
    dp_n = 1'b0;
    case (state)
      IDLE:      next_state = rise ? PRESS1 : IDLE;
      PRESS1:    if (fall) next_state = WAIT2;
                 else if (done) begin next_state = LONG_HELD; lp_n = 1'b1; end
      LONG_HELD: next_state = fall ? IDLE : LONG_HELD;
      WAIT2:     if (rise) next_state = PRESS2;
                 else if (done) begin next_state = IDLE; sp_n = 1'b1; end
      PRESS2:    if (fall) begin next_state = IDLE; dp_n = 1'b1; end
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      btn_q        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= next_state;
      btn_q        <= btn;
      short_press  <= sp_n;
      long_press   <= lp_n;
      double_press <= dp_n;
      busy         <= next_state != IDLE;
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: table-driven gestures with an event scoreboard
module tb_button_event_decoder;
  logic clk = 1'b0, reset, btn, short_press, long_press, double_press, busy;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int kind; int cyc;} exp_t;
  typedef struct {int hi1; int lo1; int hi2; int kind; int ref_sel; int off;} vec_t;
  exp_t q[$];
  vec_t vecs[8];

  button_event_decoder #(.LONG_TICKS(10), .DCLICK_TICKS(6)) dut (
    .clk(clk), .reset(reset), .btn(btn), .short_press(short_press),
    .long_press(long_press), .double_press(double_press), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // every pulse must match the oldest expected event in kind and cycle
  always @(negedge clk) begin
    int n, k;
    exp_t e;
    n = int'(short_press) + int'(long_press) + int'(double_press);
    k = short_press ? 1 : long_press ? 2 : double_press ? 3 : 0;
    if (n > 1) begin
      checks++; errors++;
      $display("FAIL multi_pulse cyc=%0d got %0d pulses, want 1", cyc, n);
    end
    if (n != 0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d kind=%0d, want none", cyc, k);
      end else begin
        e = q.pop_front();
        if (k != e.kind || cyc != e.cyc) begin
          errors++;
          $display("FAIL event got kind=%0d cyc=%0d, want kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      btn = b;
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int e, r1, r2, refc;
    vec_t v;
    vecs[0] = '{4, 0, 0, 1, 1, 6};
    vecs[1] = '{15, 0, 0, 2, 0, 10};
    vecs[2] = '{3, 2, 3, 3, 2, 0};
    vecs[3] = '{10, 0, 0, 1, 1, 6};
    vecs[4] = '{11, 0, 0, 2, 0, 10};
    vecs[5] = '{2, 6, 2, 3, 2, 0};
    vecs[6] = '{1, 1, 1, 3, 2, 0};
    vecs[7] = '{2, 1, 20, 3, 2, 0};
    reset = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    drive(0, 3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'(short_press | long_press | double_press), 0);
    reset = 1'b0;
    drive(0, 3);
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      e = cyc + 1;
      r1 = e + v.hi1;
      r2 = r1 + v.lo1 + v.hi2;
      refc = v.ref_sel == 0 ? e : v.ref_sel == 1 ? r1 : r2;
      q.push_back('{v.kind, refc + v.off});
      drive(1, v.hi1);
      if (v.hi2 > 0) begin
        drive(0, v.lo1);
        drive(1, v.hi2);
      end
      drive(0, 12);
      chk($sformatf("idle_busy_v%0d", i), int'(busy), 0);
    end
    e = cyc + 1;
    q.push_back('{2, e + 10});
    drive(1, 15);
    chk("long_held_busy", int'(busy), 1);
    drive(0, 1);
    chk("long_release_busy", int'(busy), 0);
    drive(0, 5);
    reset = 1'b1;
    drive(1, 3);
    reset = 1'b0;
    drive(1, 12);
    chk("held_at_reset_busy", int'(busy), 0);
    drive(0, 2);
    e = cyc + 1;
    q.push_back('{1, e + 3 + 6});
    drive(1, 3);
    drive(0, 12);
    chk("after_reset_gesture_q", q.size(), 0);
    drive(1, 3);
    drive(0, 2);
    chk("wait2_busy", int'(busy), 1);
    reset = 1'b1;
    drive(0, 1);
    chk("reset_wait2_busy", int'(busy), 0);
    chk("reset_wait2_pulses", int'(short_press | long_press | double_press), 0);
    reset = 1'b0;
    drive(0, 10);
    chk("post_reset_busy", int'(busy), 0);
    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
